// File: rtl/branch_pkg.sv
// Shared branch-operation encoding and 2-bit predictor counter states.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6
  } branch_op_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // NONE and the unused 3'b111 encoding are not conditional branches.
  function automatic logic is_cond_branch(input logic [2:0] op);
    return (op != BR_NONE) && (op != 3'b111);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from ALU flags; purely combinational, no flow control.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] branch_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       cond_o
);

  always_comb begin
    cond_o = 1'b0;
    case (branch_i)
      BR_BEQ:  cond_o = zero_i;
      BR_BNE:  cond_o = ~zero_i;
      BR_BLT:  cond_o = lt_i;
      BR_BGE:  cond_o = ~lt_i;
      BR_BLTU: cond_o = ltu_i;
      BR_BGEU: cond_o = ~ltu_i;
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: combinational lookup/resolve, table and stats update one edge later.
// No flow control; ex updates are accepted every cycle they are presented.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int STAT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PC_WIDTH-1:0]   fetch_pc,
  output logic                  pred_taken,
  input  logic                  ex_valid,
  input  logic [PC_WIDTH-1:0]   ex_pc,
  input  logic [2:0]            ex_branch,
  input  logic [1:0]            ex_jump,
  input  logic                  ex_zero,
  input  logic                  ex_lt,
  input  logic                  ex_ltu,
  input  logic                  ex_pred_taken,
  output logic                  pc_src,
  output logic                  mispredict,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0]      fetch_idx;
  logic [IDX_W-1:0]      ex_idx;
  logic [1:0]            bht_q [BHT_ENTRIES];
  logic [1:0]            ctr_d;
  logic [STAT_WIDTH-1:0] brs_q, brs_d;
  logic [STAT_WIDTH-1:0] mps_q, mps_d;
  logic                  cond;
  logic                  upd_en;

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign ex_idx    = ex_pc[IDX_W+1:2];

  logic unused_pc;
  assign unused_pc = ^{fetch_pc[PC_WIDTH-1:IDX_W+2], fetch_pc[1:0],
                       ex_pc[PC_WIDTH-1:IDX_W+2], ex_pc[1:0]};

  branch_cond u_cond (
    .branch_i (ex_branch),
    .zero_i   (ex_zero),
    .lt_i     (ex_lt),
    .ltu_i    (ex_ltu),
    .cond_o   (cond)
  );

  // Read path is the registered table only: same-cycle updates are not bypassed.
  assign pred_taken = bht_q[fetch_idx][1];

  assign pc_src     = ex_valid & (cond | (ex_jump != 2'b00));
  assign mispredict = ex_valid & (pc_src != ex_pred_taken);
  assign upd_en     = ex_valid & (ex_jump == 2'b00) & is_cond_branch(ex_branch);

  always_comb begin
    ctr_d = bht_q[ex_idx];
    if (pc_src) begin
      if (ctr_d != ST) ctr_d = ctr_d + 2'd1;
    end else begin
      if (ctr_d != SNT) ctr_d = ctr_d - 2'd1;
    end
  end

  always_comb begin
    brs_d = brs_q;
    mps_d = mps_q;
    if (brs_q != '1) brs_d = brs_q + 1'b1;
    if (mispredict && (mps_q != '1)) mps_d = mps_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= WNT;
      brs_q <= '0;
      mps_q <= '0;
    end else if (upd_en) begin
      bht_q[ex_idx] <= ctr_d;
      brs_q         <= brs_d;
      mps_q         <= mps_d;
    end
  end

  assign stat_branches    = brs_q;
  assign stat_mispredicts = mps_q;

endmodule
